// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states
// and byte-lane count.
package lsu_pkg;

   localparam int LANES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
// Size 11 falls through to whole-word behaviour.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [1:0]            off_i,
   input  logic [1:0]            size_i,
   input  logic                  uns_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [DATA_WIDTH-1:0] merged_o
);

   localparam int SW = $clog2(DATA_WIDTH);

   logic [SW-1:0] bsh;
   logic [SW-1:0] hsh;
   logic [7:0]    b;
   logic [15:0]   h;

   assign bsh = SW'({off_i, 3'b000});
   assign hsh = SW'({off_i[1], 4'b0000});
   assign b   = word_i[bsh +: 8];
   assign h   = word_i[hsh +: 16];

   always_comb begin
      rdata_o  = word_i;
      merged_o = wdata_i;
      case (size_i)
         SZ_BYTE: begin
            rdata_o = {{(DATA_WIDTH-8){b[7] & ~uns_i}}, b};
            merged_o = word_i;
            merged_o[bsh +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            rdata_o = {{(DATA_WIDTH-16){h[15] & ~uns_i}}, h};
            merged_o = word_i;
            merged_o[hsh +: 16] = wdata_i[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator with read-modify-write sub-word stores.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests answer with resp_err.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   state_e                state_q, state_d;
   logic                  we_q, uns_q, err_q;
   logic [1:0]            size_q, off_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, word_q, wr_data_q;
   logic [DATA_WIDTH-1:0] ld_data, merged;
   logic                  accept, mis;

   assign req_ready = (state_q == S_IDLE) && !rst;
   assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis = (req_size == SZ_HALF && req_addr[0])
             || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
             || (req_size == 2'b11);
   assign resp_err = (state_q == S_RESP) && err_q;
`else
   assign mis      = 1'b0;
   assign resp_err = 1'b0;
`endif

   lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .word_i  (word_q),
      .wdata_i (wdata_q),
      .off_i   (off_q),
      .size_i  (size_q),
      .uns_i   (uns_q),
      .rdata_o (ld_data),
      .merged_o(merged)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (mis)                        state_d = S_RESP;
               else if (req_we && req_size[1]) state_d = S_WRITE;
               else                            state_d = S_READ;
            end
         end
         S_READ:  state_d = we_q ? S_WRITE : S_RESP;
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= SZ_BYTE;
         off_q      <= 2'b00;
         mem_addr_q <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= mis;
            size_q  <= req_size;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            // a trapped request never touches the memory port
            if (!mis) mem_addr_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
         end
         if (state_q == S_READ)  word_q    <= mem_rd_data;
         if (state_q == S_WRITE) wr_data_q <= merged;
      end
   end

   assign mem_wr_en   = (state_q == S_WRITE);
   assign mem_addr    = mem_addr_q;
   assign mem_wr_data = mem_wr_en ? merged : wr_data_q;
   assign resp_valid  = (state_q == S_RESP);
   assign resp_rdata  = (resp_valid && !we_q && !err_q) ? ld_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random checks of load_store_unit against a word-array
// reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, mem_wr_en;
   logic [31:0] resp_rdata, mem_addr, mem_wr_data, mem_rd_data;

   logic [31:0] mem  [16];
   logic [31:0] refm [16];

   int nerr = 0;
   int nchk = 0;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   assign mem_rd_data = mem[mem_addr[5:2]];
   always @(posedge clk) if (mem_wr_en) mem[mem_addr[5:2]] <= mem_wr_data;

   // observations of the last transaction, cycle 1..5 after accept
   int          nresp, nwr, resp_cyc, wr_cyc;
   logic [31:0] rd_seen;
   logic        err_seen;
   logic        rdy_at [6];
   logic [31:0] addr_at [6];
   logic [31:0] wd_at [6];

   // expectations of the last transaction
   logic [31:0] exp_rd;
   logic        exp_err;
   int          exp_lat, exp_nwr;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w,
      input logic [1:0] sz, input logic uns, input logic [31:0] a);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (8 * a[1:0])) & 32'hFF;
         if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
         v = (w >> (16 * a[1])) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w,
      input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] m;
      if (sz == 2'd0) begin
         m = 32'hFF << (8 * a[1:0]);
         return (w & ~m) | ((wd & 32'hFF) << (8 * a[1:0]));
      end else if (sz == 2'd1) begin
         m = 32'hFFFF << (16 * a[1]);
         return (w & ~m) | ((wd & 32'hFFFF) << (16 * a[1]));
      end
      return wd;
   endfunction

   task automatic model(input logic we, input logic [1:0] sz,
      input logic uns, input logic [31:0] a, input logic [31:0] wd);
      logic mis;
      mis = TRAP && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
                     || sz == 2'd3);
      exp_rd  = 32'h0;
      exp_err = mis;
      exp_nwr = 0;
      if (mis) begin
         exp_lat = 1;
      end else if (!we) begin
         exp_lat = 2;
         exp_rd  = ref_load(refm[a[5:2]], sz, uns, a);
      end else begin
         exp_lat = sz[1] ? 2 : 3;
         exp_nwr = 1;
         refm[a[5:2]] = ref_store(refm[a[5:2]], sz, a, wd);
      end
   endtask

   task automatic xact(input logic we, input logic [1:0] sz,
      input logic uns, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz;
      req_unsigned = uns; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      nresp = 0; nwr = 0; resp_cyc = -1; wr_cyc = -1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         rdy_at[c]  = req_ready;
         addr_at[c] = mem_addr;
         wd_at[c]   = mem_wr_data;
         if (mem_wr_en) begin nwr++; wr_cyc = c; end
         if (resp_valid) begin
            nresp++; resp_cyc = c;
            rd_seen = resp_rdata; err_seen = resp_err;
         end
      end
   endtask

   task automatic run(input string tag, input logic we, input logic [1:0] sz,
      input logic uns, input logic [31:0] a, input logic [31:0] wd);
      xact(we, sz, uns, a, wd);
      model(we, sz, uns, a, wd);
      chk({tag, "_nresp"}, nresp, 1);
      chk({tag, "_lat"}, resp_cyc, exp_lat);
      chk({tag, "_rdata"}, rd_seen, exp_rd);
      chk({tag, "_err"}, err_seen, exp_err);
      chk({tag, "_nwr"}, nwr, exp_nwr);
      if (exp_nwr == 1) chk({tag, "_wrcyc"}, wr_cyc, exp_lat - 1);
      chk({tag, "_mem"}, mem[a[5:2]], refm[a[5:2]]);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 16; i++) begin
         mem[i] = $urandom; refm[i] = mem[i];
      end
      mem[4] = 32'h8899AABB; refm[4] = 32'h8899AABB;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_wr_data", mem_wr_data, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_err", resp_err, 0);
      rst = 1'b0;
      #1 chk("rel_ready", req_ready, 1);

      run("lb13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      chk("lb13_val", rd_seen, 32'hFFFFFF88);
      chk("lb13_ready_c3", rdy_at[3], 1);
      run("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      chk("lbu13_val", rd_seen, 32'h00000088);
      run("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
      chk("lh12_val", rd_seen, 32'hFFFF8899);
      run("lhu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
      chk("lhu12_val", rd_seen, 32'h00008899);
      run("lh10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
      chk("lh10_val", rd_seen, 32'hFFFFAABB);
      run("lw11", 1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
      chk("lw11_val", rd_seen, TRAP ? 32'h0 : 32'h8899AABB);
      chk("lw11_err", err_seen, TRAP);

      run("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h55);
      chk("sb11_rd_addr", addr_at[1], 32'h10);
      chk("sb11_wr_data", wd_at[2], 32'h889955BB);
      chk("sb11_memval", mem[4], 32'h889955BB);

      run("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      chk("sw10_ready_c1", rdy_at[1], 0);
      chk("sw10_ready_c2", rdy_at[2], 0);
      chk("sw10_ready_c3", rdy_at[3], 1);
      chk("sw10_wr_data", wd_at[1], 32'hDEADBEEF);

      // halfword store abandoned by reset during its WRITE cycle
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1;
      req_unsigned = 1'b0; req_addr = 32'h12; req_wdata = 32'h1234;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("sh_rst_wr_before", mem_wr_en, 1);
      rst = 1'b1;
      #1;
      chk("sh_rst_wr_drop", mem_wr_en, 0);
      chk("sh_rst_ready", req_ready, 0);
      chk("sh_rst_resp", resp_valid, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("sh_rel_ready", req_ready, 1);
      nresp = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (resp_valid) nresp++;
      end
      chk("sh_rst_no_resp", nresp, 0);
      chk("sh_rst_mem", mem[4], refm[4]);

      for (int i = 0; i < 40; i++) begin
         run("rand", 1'($urandom), 2'($urandom), 1'($urandom),
             32'($urandom_range(0, 63)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store initiator between the MIPS32 datapath and the word-organised data memory. It accepts one byte, halfword or word load/store request and drives the memory's write-enable, address and write-data ports. It samples the memory's combinational read data. Sub-word stores use read-modify-write because the memory writes whole words only.

## Interface
- DATA_WIDTH, 32: data word width; byte lanes = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte-address width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend loads (lbu/lhu); ignored for stores.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- resp_err  out  1  misalignment error; constant 0 unless LSU_MISALIGN_TRAP_EN.
- mem_wr_en  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2], 2'b00}.
- mem_wr_data  out  DATA_WIDTH  full word to write.
- mem_rd_data  in  DATA_WIDTH  combinational read of mem_addr.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE
  - req_ready=1 (0 while rst is high).
  - When req_valid&&req_ready, latch we/size/unsigned/addr/wdata.
  - Next state: loads and sub-word stores go to READ; word stores go to WRITE.
- READ: mem_addr driven from the latched address; mem_rd_data captured into word_q at the edge.
  - Loads go to RESP.
  - Stores go to WRITE.
- WRITE
  - mem_wr_en=1 for exactly this cycle.
  - mem_wr_data is req_wdata for word stores; for sub-word stores it is word_q with the selected lane(s) replaced.
  - Next state: RESP.
- RESP: resp_valid=1 for one cycle; no backpressure. Next state: IDLE.
- Lane selection (little-endian):
  - Byte lane = addr[1:0]: bits [8*lane+7 : 8*lane].
  - Halfword lane = addr[1]: bits [16*lane+15 : 16*lane].
- Load extension: sign-extend from bit 7/15 unless req_unsigned; word loads unmodified.
- Without the trap macro:
  - Halfword ignores addr[0].
  - Word ignores addr[1:0].
  - size 11 is treated as word.
- mem_addr and mem_wr_data hold their last values outside READ/WRITE.
- Requests are never accepted outside IDLE.

## Timing
- Accept edge = cycle 0.
- Load: READ in cycle 1, resp_valid in cycle 2; next accept possible at the end of cycle 3 (IDLE).
- Word store: WRITE in cycle 1, resp_valid in cycle 2.
- Sub-word store: READ in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
- Reset values: state IDLE; resp_valid 0, resp_rdata 0, resp_err 0, mem_wr_en 0, mem_addr 0, mem_wr_data 0, word_q 0; req_ready 0 while rst is asserted.
- Reset mid-operation: the request is abandoned and no response is issued.
  - mem_wr_en is derived from state, so it deasserts asynchronously; a store in WRITE is suppressed if rst rises before that edge.
- req_ready returns to 1 in the first cycle after rst deasserts.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - These requests are misaligned: halfword with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - A misaligned request goes IDLE→RESP directly, with resp_err=1 and resp_rdata=0.
  - No READ/WRITE occurs and mem_wr_en stays 0.
- Undefined: there is no error detection and resp_err is tied 0. Misaligned addresses are silently truncated as described in Operation.

## Structure
- Shared package lsu_pkg holds:
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state enum;
  - the byte-lane count constant.
- One sub-module, lsu_lane_align, is purely combinational:
  - load extraction and extension (word, addr[1:0], size, unsigned → rdata);
  - store merge (word_q, wdata, addr[1:0], size → merged word).
- The FSM and registers live in load_store_unit.

## Test plan
- Memory word 0x10 = 0x8899AABB:
  - LB 0x13 → resp_rdata 0xFFFFFF88.
  - LBU 0x13 → 0x00000088.
  - resp_valid in cycle 2 after accept; mem_wr_en never asserted.
- LH 0x12 → 0xFFFF8899. LHU 0x12 → 0x00008899. LH 0x10 → 0xFFFFAABB.
- SB 0x11, wdata 0x00000055:
  - mem_addr 0x10 in READ; WRITE cycle 2 with mem_wr_data 0x889955BB.
  - Memory holds 0x889955BB; resp_valid in cycle 3 with resp_rdata 0.
- SW 0x10, wdata 0xDEADBEEF: no READ; mem_wr_en only in cycle 1; resp_valid in cycle 2; req_ready 0 for cycles 1–2.
- LW 0x11:
  - Without the macro → 0x8899AABB, resp_err 0.
  - With LSU_MISALIGN_TRAP_EN → resp_valid in cycle 1, resp_err 1, rdata 0, no memory access.
- SH 0x12, wdata 0x1234, with rst pulsed during the WRITE cycle before the edge:
  - mem_wr_en drops immediately and memory is unchanged.
  - No resp_valid is issued.
  - req_ready is 1 the cycle after rst release.
